// File: rtl/mxint_requantizer.sv
// mxint_requantizer: three-stage pipelined narrowing cast for MxInt blocks.
// Each beat carries BLOCK_SIZE signed mantissas plus one shared biased
// exponent. The block is renormalised so its widest element just fits the
// output mantissa width, then rounded (half up), saturated and re-biased.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mdata_in_0        BLOCK_SIZE x W_IN signed input mantissas
//   edata_in_0        shared input exponent (EW_IN bits, biased)
//   data_in_0_valid   input beat valid
//   data_in_0_ready   input beat accepted when valid && ready
//   mdata_out_0       BLOCK_SIZE x W_OUT signed output mantissas
//   edata_out_0       shared output exponent (EW_OUT bits, biased)
//   data_out_0_valid  output beat valid
//   data_out_0_ready  downstream ready
module mxint_requantizer #(
    parameter int unsigned DATA_IN_0_PRECISION_0  = 24,
    parameter int unsigned DATA_IN_0_PRECISION_1  = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_0 = 8,
    parameter int unsigned DATA_OUT_0_PRECISION_1 = 8,
    parameter int unsigned BLOCK_SIZE             = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [DATA_IN_0_PRECISION_0-1:0]   mdata_in_0 [BLOCK_SIZE],
    input  logic [DATA_IN_0_PRECISION_1-1:0]          edata_in_0,
    input  logic                                      data_in_0_valid,
    output logic                                      data_in_0_ready,
    output logic signed [DATA_OUT_0_PRECISION_0-1:0]  mdata_out_0 [BLOCK_SIZE],
    output logic [DATA_OUT_0_PRECISION_1-1:0]         edata_out_0,
    output logic                                      data_out_0_valid,
    input  logic                                      data_out_0_ready
);

    localparam int unsigned W_IN   = DATA_IN_0_PRECISION_0;
    localparam int unsigned EW_IN  = DATA_IN_0_PRECISION_1;
    localparam int unsigned W_OUT  = DATA_OUT_0_PRECISION_0;
    localparam int unsigned EW_OUT = DATA_OUT_0_PRECISION_1;
    localparam int unsigned BS     = BLOCK_SIZE;

    // Width of an element-width count (1..W_IN).
    localparam int unsigned NW = $clog2(W_IN + 1);
    // Signed shift amount s = n_max - W_OUT.
    localparam int unsigned SW = $clog2(W_IN + W_OUT) + 1;
    // Signed working width for the exponent arithmetic.
    localparam int unsigned EC = ((EW_IN > EW_OUT) ? EW_IN : EW_OUT) + 8;
    // Mantissa plus one guard bit so the rounding add cannot wrap.
    localparam int unsigned WW = W_IN + 1;

    localparam int unsigned BIAS_IN  = (2 ** (EW_IN - 1)) - 1;
    localparam int unsigned BIAS_OUT = (2 ** (EW_OUT - 1)) - 1;
    localparam int unsigned E_MAX    = (2 ** EW_OUT) - 1;

    // Constant part of e_out = e_in + s + E_OFS.
    localparam int E_OFS = int'(BIAS_OUT) + int'(W_OUT) - 1
                         - int'(BIAS_IN) - int'(W_IN) + 1;

    localparam logic signed [EC-1:0]    E_MAX_W      = EC'(E_MAX);
    localparam logic signed [EC-1:0]    E_OFS_W      = EC'(E_OFS);
    localparam logic signed [WW-1:0]    MAX_POS_WIDE = WW'((2 ** (W_OUT - 1)) - 1);
    localparam logic [W_OUT-1:0]        MAX_POS      = W_OUT'((2 ** (W_OUT - 1)) - 1);
    localparam logic [W_OUT-1:0]        MIN_NEG      = {1'b1, {(W_OUT-1){1'b0}}};

    // Minimum two's-complement width: index of the highest bit that differs
    // from the sign bit, plus two (one for that bit, one for the sign).
    function automatic logic [NW-1:0] min_width(input logic [W_IN-1:0] m);
        logic [NW-1:0] n;
        n = NW'(1);
        for (int i = 0; i < int'(W_IN) - 1; i++) begin
            if (m[i] != m[W_IN-1]) n = NW'(i + 2);
        end
        return n;
    endfunction

    // Shift one mantissa into the output width: round half up and clamp when
    // narrowing, exact left shift otherwise.
    function automatic logic [W_OUT-1:0] narrow(input logic signed [W_IN-1:0] m,
                                                input logic signed [SW-1:0]   s);
        logic signed [WW-1:0] sum;
        logic signed [WW-1:0] rnd;
        logic [SW-1:0]        amt;
        logic [W_OUT-1:0]     res;
        sum = '0;
        rnd = '0;
        amt = '0;
        res = '0;
        if (!s[SW-1] && (s != '0)) begin
            amt = s;
            sum = {m[W_IN-1], m} + (WW'(1) << (amt - SW'(1)));
            rnd = sum >>> amt;
            // Only the positive side can exceed the range after rounding.
            if (rnd > MAX_POS_WIDE) res = MAX_POS;
            else                    res = W_OUT'(rnd);
        end else begin
            amt = -s;
            res = W_OUT'(m) << amt;
        end
        return res;
    endfunction

    // Pipeline advances whenever the output register is free or draining.
    logic advance;
    assign advance         = !data_out_0_valid || data_out_0_ready;
    assign data_in_0_ready = advance;

    // ---------------- stage 1: capture input and per-element widths
    logic                     s1_valid_q, s1_valid_d;
    logic signed [W_IN-1:0]   s1_m_q [BS];
    logic signed [W_IN-1:0]   s1_m_d [BS];
    logic [NW-1:0]            s1_n_q [BS];
    logic [NW-1:0]            s1_n_d [BS];
    logic [EW_IN-1:0]         s1_e_q, s1_e_d;

    always_comb begin : s1_next
        s1_valid_d = s1_valid_q;
        s1_e_d     = s1_e_q;
        for (int i = 0; i < int'(BS); i++) begin
            s1_m_d[i] = s1_m_q[i];
            s1_n_d[i] = s1_n_q[i];
        end
        if (advance) begin
            s1_valid_d = data_in_0_valid;
            s1_e_d     = edata_in_0;
            for (int i = 0; i < int'(BS); i++) begin
                s1_m_d[i] = mdata_in_0[i];
                s1_n_d[i] = min_width(mdata_in_0[i]);
            end
        end
    end

    // ---------------- stage 2: block width, shift, exponent and flags
    logic [NW-1:0]            n_max_c;
    logic                     zero_c;
    logic signed [SW-1:0]     shift_c;
    logic signed [EC-1:0]     e_wide_c;

    logic                     s2_valid_q, s2_valid_d;
    logic signed [W_IN-1:0]   s2_m_q [BS];
    logic signed [W_IN-1:0]   s2_m_d [BS];
    logic signed [SW-1:0]     s2_shift_q, s2_shift_d;
    logic [EW_OUT-1:0]        s2_e_q, s2_e_d;
    logic                     s2_kill_q, s2_kill_d;   // all-zero block or underflow
    logic                     s2_ovf_q, s2_ovf_d;     // exponent above range

    always_comb begin : s2_next
        n_max_c = NW'(1);
        zero_c  = 1'b1;
        for (int i = 0; i < int'(BS); i++) begin
            if (s1_n_q[i] > n_max_c) n_max_c = s1_n_q[i];
            if (s1_m_q[i] != '0)     zero_c  = 1'b0;
        end
        shift_c  = SW'(n_max_c) - SW'(W_OUT);
        e_wide_c = EC'(s1_e_q) + {{(EC-SW){shift_c[SW-1]}}, shift_c} + E_OFS_W;

        s2_valid_d = s2_valid_q;
        s2_shift_d = s2_shift_q;
        s2_e_d     = s2_e_q;
        s2_kill_d  = s2_kill_q;
        s2_ovf_d   = s2_ovf_q;
        for (int i = 0; i < int'(BS); i++) s2_m_d[i] = s2_m_q[i];
        if (advance) begin
            s2_valid_d = s1_valid_q;
            s2_shift_d = shift_c;
            s2_e_d     = EW_OUT'(e_wide_c);
            s2_kill_d  = zero_c || e_wide_c[EC-1];
            s2_ovf_d   = e_wide_c > E_MAX_W;
            for (int i = 0; i < int'(BS); i++) s2_m_d[i] = s1_m_q[i];
        end
    end

    // ---------------- stage 3: shift, round, saturate into output registers
    logic                     out_valid_q, out_valid_d;
    logic signed [W_OUT-1:0]  out_m_q [BS];
    logic signed [W_OUT-1:0]  out_m_d [BS];
    logic [EW_OUT-1:0]        out_e_q, out_e_d;

    always_comb begin : s3_next
        out_valid_d = out_valid_q;
        out_e_d     = out_e_q;
        for (int i = 0; i < int'(BS); i++) out_m_d[i] = out_m_q[i];
        if (advance) begin
            out_valid_d = s2_valid_q;
            if (s2_kill_q) begin
                out_e_d = '0;
                for (int i = 0; i < int'(BS); i++) out_m_d[i] = '0;
            end else if (s2_ovf_q) begin
                // Exponent clamps to max; nonzero mantissas go to full scale by sign.
                out_e_d = '1;
                for (int i = 0; i < int'(BS); i++) begin
                    if (s2_m_q[i] == '0)         out_m_d[i] = '0;
                    else if (s2_m_q[i][W_IN-1])  out_m_d[i] = MIN_NEG;
                    else                         out_m_d[i] = MAX_POS;
                end
            end else begin
                out_e_d = s2_e_q;
                for (int i = 0; i < int'(BS); i++) out_m_d[i] = narrow(s2_m_q[i], s2_shift_q);
            end
        end
    end

    // ---------------- state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_e_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_shift_q  <= '0;
            s2_e_q      <= '0;
            s2_kill_q   <= 1'b0;
            s2_ovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_e_q     <= '0;
            for (int i = 0; i < int'(BS); i++) begin
                s1_m_q[i]  <= '0;
                s1_n_q[i]  <= '0;
                s2_m_q[i]  <= '0;
                out_m_q[i] <= '0;
            end
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_e_q      <= s1_e_d;
            s2_valid_q  <= s2_valid_d;
            s2_shift_q  <= s2_shift_d;
            s2_e_q      <= s2_e_d;
            s2_kill_q   <= s2_kill_d;
            s2_ovf_q    <= s2_ovf_d;
            out_valid_q <= out_valid_d;
            out_e_q     <= out_e_d;
            for (int i = 0; i < int'(BS); i++) begin
                s1_m_q[i]  <= s1_m_d[i];
                s1_n_q[i]  <= s1_n_d[i];
                s2_m_q[i]  <= s2_m_d[i];
                out_m_q[i] <= out_m_d[i];
            end
        end
    end

    // Output ports are driven straight from the stage-3 registers.
    assign data_out_0_valid = out_valid_q;
    assign edata_out_0      = out_e_q;
    always_comb begin : out_drive
        for (int i = 0; i < int'(BS); i++) mdata_out_0[i] = out_m_q[i];
    end

endmodule

// File: tb/tb_mxint_requantizer.sv
// Self-checking bench for mxint_requantizer (24b/8b in, 8b/8b out, 4 lanes).
module tb_mxint_requantizer;

    localparam int BS = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] m_in [BS];
    logic [7:0]         e_in;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  m_out [BS];
    logic [7:0]         e_out;
    logic               out_valid;
    logic               out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mxint_requantizer #(
        .DATA_IN_0_PRECISION_0  (24),
        .DATA_IN_0_PRECISION_1  (8),
        .DATA_OUT_0_PRECISION_0 (8),
        .DATA_OUT_0_PRECISION_1 (8),
        .BLOCK_SIZE             (BS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mdata_in_0       (m_in),
        .edata_in_0       (e_in),
        .data_in_0_valid  (in_valid),
        .data_in_0_ready  (in_ready),
        .mdata_out_0      (m_out),
        .edata_out_0      (e_out),
        .data_out_0_valid (out_valid),
        .data_out_0_ready (out_ready)
    );

    typedef struct { int m [BS]; int e; int xm [BS]; int xe; } vec_t;
    typedef struct { int m [BS]; int e; } blk_t;

    blk_t exp_q [$];
    vec_t tbl [11];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Smallest n with -2^(n-1) <= v <= 2^(n-1)-1.
    function automatic int min_bits(input int v);
        for (int n = 1; n <= 32; n++) begin
            longint lim = longint'(1) << (n - 1);
            if (longint'(v) >= -lim && longint'(v) <= lim - 1) return n;
        end
        return 32;
    endfunction

    // Reference: value-level requantisation with floor division for rounding.
    function automatic void model(input int m [BS], input int e, output blk_t r);
        int nmax;
        bit allz;
        int s;
        int eo;
        longint num, den, q;
        nmax = 1;
        allz = 1'b1;
        for (int i = 0; i < BS; i++) begin
            if (min_bits(m[i]) > nmax) nmax = min_bits(m[i]);
            if (m[i] != 0) allz = 1'b0;
            r.m[i] = 0;
        end
        r.e = 0;
        s  = nmax - 8;
        eo = e - 127 - 23 + s + 127 + 7;
        if (allz || eo < 0) return;
        if (eo > 255) begin
            r.e = 255;
            for (int i = 0; i < BS; i++) r.m[i] = (m[i] > 0) ? 127 : ((m[i] < 0) ? -128 : 0);
            return;
        end
        r.e = eo;
        for (int i = 0; i < BS; i++) begin
            if (s > 0) begin
                num = longint'(m[i]) + (longint'(1) << (s - 1));
                den = longint'(1) << s;
                q   = num / den;
                if ((num % den) != 0 && num < 0) q = q - 1;
                if (q > 127) q = 127;
                r.m[i] = int'(q);
            end else begin
                r.m[i] = m[i] * (1 << (-s));
            end
        end
    endfunction

    task automatic check_out(input string nm, input blk_t x);
        for (int i = 0; i < BS; i++)
            chk($sformatf("%s m[%0d]", nm, i), int'(m_out[i]), x.m[i]);
        chk({nm, " e"}, int'(e_out), x.e);
    endtask

    // Single block through an idle pipeline; checks latency and result.
    task automatic run_vec(input vec_t v, input string nm);
        int   lat;
        blk_t x;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        e_in      = 8'(v.e);
        for (int i = 0; i < BS; i++) m_in[i] = 24'(v.m[i]);
        #1;
        chk({nm, " accept ready"}, int'(in_ready), 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({nm, " latency"}, lat, 3);
        for (int i = 0; i < BS; i++) x.m[i] = v.xm[i];
        x.e = v.xe;
        check_out(nm, x);
    endtask

    // Random stream with optional input bubbles and random downstream stalls.
    task automatic random_phase(input int nblk, input bit bubbles, input string nm);
        int   sent;
        int   got;
        int   cyc;
        int   w;
        int   cur_m [BS];
        int   cur_e;
        bit   fire;
        blk_t x;
        sent = 0;
        got  = 0;
        cyc  = 0;
        fire = 1'b0;
        cur_e = 0;
        for (int i = 0; i < BS; i++) cur_m[i] = 0;
        in_valid = 1'b0;
        while ((sent < nblk || exp_q.size() > 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (fire) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 1) == 1);
            if (sent < nblk && !in_valid && (!bubbles || $urandom_range(0, 3) != 0)) begin
                for (int i = 0; i < BS; i++) begin
                    if ($urandom_range(0, 7) == 0) cur_m[i] = 0;
                    else begin
                        w = int'($urandom_range(1, 24));
                        cur_m[i] = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
                    end
                end
                if ($urandom_range(0, 9) == 0)
                    for (int i = 0; i < BS; i++) cur_m[i] = 0;
                cur_e = int'($urandom_range(0, 255));
                for (int i = 0; i < BS; i++) m_in[i] = 24'(cur_m[i]);
                e_in     = 8'(cur_e);
                in_valid = 1'b1;
            end
            #1;
            chk({nm, " in_ready"}, int'(in_ready), int'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s extra output: got valid block expected none", nm);
                end else begin
                    check_out(nm, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            fire = in_valid && in_ready;
            if (fire) begin
                model(cur_m, cur_e, x);
                exp_q.push_back(x);
                sent++;
            end
        end
        chk({nm, " delivered"}, got, nblk);
        chk({nm, " leftover"}, exp_q.size(), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{'{1000, -1000, 3, 0},             130, '{125, -125, 0, 0},        117};
        tbl[1]  = '{'{1023, 0, 0, 0},                 130, '{127, 0, 0, 0},           117};
        tbl[2]  = '{'{5, -3, 0, 1},                   100, '{80, -48, 0, 16},         80};
        tbl[3]  = '{'{0, 0, 0, 0},                    77,  '{0, 0, 0, 0},             0};
        tbl[4]  = '{'{5, 0, 0, 0},                    10,  '{0, 0, 0, 0},             0};
        tbl[5]  = '{'{8388607, -8388608, 0, 1},       200, '{127, -128, 0, 0},        200};
        tbl[6]  = '{'{127, -128, 1, -1},              127, '{127, -128, 1, -1},       111};
        tbl[7]  = '{'{300, -12, 4, -4},               130, '{75, -3, 1, -1},          116};
        tbl[8]  = '{'{1, 0, 0, 0},                    22,  '{64, 0, 0, 0},            0};
        tbl[9]  = '{'{1, 0, 0, 0},                    21,  '{0, 0, 0, 0},             0};
        tbl[10] = '{'{-1, -1, -1, -1},                255, '{-128, -128, -128, -128}, 232};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e_in      = '0;
        for (int i = 0; i < BS; i++) m_in[i] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset valid", int'(out_valid), 0);
        chk("reset ready", int'(in_ready), 1);
        chk("reset e", int'(e_out), 0);
        for (int i = 0; i < BS; i++) chk($sformatf("reset m[%0d]", i), int'(m_out[i]), 0);

        for (int k = 0; k < 11; k++) run_vec(tbl[k], $sformatf("vec%0d", k));

        random_phase(8, 1'b0, "b2b");
        random_phase(150, 1'b1, "rand");

        // Reset with two blocks in flight.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        e_in      = 8'(tbl[0].e);
        for (int i = 0; i < BS; i++) m_in[i] = 24'(tbl[0].m[i]);
        @(posedge clk);
        @(negedge clk);
        e_in = 8'(tbl[2].e);
        for (int i = 0; i < BS; i++) m_in[i] = 24'(tbl[2].m[i]);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst valid", int'(out_valid), 0);
        chk("midrst ready", int'(in_ready), 1);
        chk("midrst e", int'(e_out), 0);
        for (int i = 0; i < BS; i++) chk($sformatf("midrst m[%0d]", i), int'(m_out[i]), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("midrst idle%0d", k), int'(out_valid), 0);
        end
        run_vec(tbl[7], "post-rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
